// File: rtl/serial_lane_scheduler_if.sv
// Handshake and serial-line bundle for serial_lane_scheduler.
// Producers drive req_valid/req_data; the scheduler drives the rest.
interface serial_lane_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      ser_out;
  logic                      ser_frame;
  logic [GW-1:0]             grant_id;
  logic                      busy;
  logic                      drop_pulse;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready,
    input  ser_out,
    input  ser_frame,
    input  grant_id,
    input  busy,
    input  drop_pulse
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready,
    output ser_out,
    output ser_frame,
    output grant_id,
    output busy,
    output drop_pulse
  );
endinterface

// File: rtl/serial_lane_scheduler.sv
// Round-robin scheduler framing one lane word at a time onto ser_out.
// Optional DUP_SUPPRESS_EN discards a repeat of a lane's last sent word.
module serial_lane_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  serial_lane_scheduler_if.slave  bus
);

  localparam int GW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(DATA_W);
  localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    SHIFT,
    GAP
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [GW-1:0]     rr_ptr_q;
  logic [GW-1:0]     rr_ptr_d;
  logic [GW-1:0]     grant_q;
  logic [GW-1:0]     grant_d;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic [CW-1:0]     bit_q;
  logic [CW-1:0]     bit_d;
  logic [GCW-1:0]    gap_q;
  logic [GCW-1:0]    gap_d;
  logic              ser_q;
  logic              ser_d;
  logic              frame_q;
  logic              frame_d;
  logic              busy_q;
  logic              busy_d;

  logic [GW-1:0]      pick;
  logic               found;
  logic [DATA_W-1:0]  word;
  logic               hs;
  logic               dup;
  logic [NUM_REQ-1:0] ready;

  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    int idx;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  assign word = bus.req_data[int'(pick)*DATA_W +: DATA_W];
  assign hs   = (state_q == IDLE) && found && !reset;

  // ready is a one-hot of the pick, only in IDLE
  always_comb begin
    ready = '0;
    if (hs) ready[pick] = 1'b1;
  end

  assign bus.req_ready = ready;

`ifdef DUP_SUPPRESS_EN
  logic [DATA_W-1:0]  last_word_q [NUM_REQ];
  logic [NUM_REQ-1:0] last_vld_q;
  logic               drop_q;

  assign dup = last_vld_q[pick] && (word == last_word_q[pick]);

  // remember the last word actually framed per lane
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) last_word_q[i] <= '0;
      last_vld_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      drop_q <= hs && dup;
      if (hs && !dup) begin
        last_word_q[pick] <= word;
        last_vld_q[pick]  <= 1'b1;
      end
    end
  end

  assign bus.drop_pulse = drop_q;
`else
  assign dup            = 1'b0;
  assign bus.drop_pulse = 1'b0;
`endif

  // next state, datapath and registered-output values
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          rr_ptr_d = (int'(pick) == NUM_REQ - 1) ? '0 : pick + 1'b1;
          if (!dup) begin
            state_d = START;
            shift_d = word;
            grant_d = pick;
          end
        end
      end
      START: begin
        bit_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        shift_d = shift_q << 1;
        if (bit_q == CW'(DATA_W - 1)) begin
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      GAP: begin
        if (int'(gap_q) == GAP_CYCLES - 1) state_d = IDLE;
        else gap_d = gap_q + 1'b1;
      end
    endcase

    ser_d   = 1'b0;
    frame_d = 1'b0;
    busy_d  = (state_d != IDLE);
    unique case (state_d)
      START: begin
        ser_d   = 1'b1;
        frame_d = 1'b1;
      end
      SHIFT: begin
        ser_d   = shift_d[DATA_W-1];
        frame_d = 1'b1;
      end
      default: begin
        ser_d   = 1'b0;
        frame_d = 1'b0;
      end
    endcase
  end

  // state and output registers; reset aborts any frame
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      shift_q  <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      ser_q    <= 1'b0;
      frame_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      ser_q    <= ser_d;
      frame_q  <= frame_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.ser_out   = ser_q;
  assign bus.ser_frame = frame_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_serial_lane_scheduler.sv
// Directed bench for serial_lane_scheduler.
// u0 uses GAP_CYCLES=1, u1 uses GAP_CYCLES=0.
module tb_serial_lane_scheduler;

  localparam int NR = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  logic [7:0] seq = 8'h40;

  always #5 clk = ~clk;

  serial_lane_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW)) b0 ();
  serial_lane_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW)) b1 ();

  serial_lane_scheduler #(
    .NUM_REQ(NR), .DATA_W(DW), .GAP_CYCLES(1)
  ) u0 (
    .clock(clk),
    .reset(rst),
    .bus(b0)
  );

  serial_lane_scheduler #(
    .NUM_REQ(NR), .DATA_W(DW), .GAP_CYCLES(0)
  ) u1 (
    .clock(clk),
    .reset(rst),
    .bus(b1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 40 && b0.busy; c++) step();
    chk("idle_to", 32'(b0.busy), 0);
  endtask

  // valid is held by caller; waits for grant g with a fresh word
  task automatic serve(input int g, input string tag);
    b0.req_data[g*DW +: DW] = seq;
    seq = seq + 8'd1;
    #1;
    for (int c = 0; c < 40 && b0.req_ready == '0; c++) begin
      step();
      #1;
    end
    chk({tag, "_rdy"}, 32'(b0.req_ready), 32'(1 << g));
    step();
    chk({tag, "_gid"}, 32'(b0.grant_id), 32'(g));
    chk({tag, "_nordy"}, 32'(b0.req_ready), 0);
  endtask

  // lone requester 0 sends d; exp_frame says if it must be framed
  task automatic tx(input logic [7:0] d, input logic exp_frame,
                    input string tag);
    b0.req_valid = 4'b0001;
    b0.req_data[7:0] = d;
    #1;
    for (int c = 0; c < 40 && b0.req_ready == '0; c++) begin
      step();
      #1;
    end
    chk({tag, "_rdy"}, 32'(b0.req_ready), 1);
    step();
    b0.req_valid = '0;
    chk({tag, "_busy"}, 32'(b0.busy), 32'(exp_frame));
    chk({tag, "_frm"}, 32'(b0.ser_frame), 32'(exp_frame));
    chk({tag, "_drop"}, 32'(b0.drop_pulse), 32'(!exp_frame));
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [8:0] exp_a5;
    int hs_t [3];
    int n_hs;
    logic pend;

    b0.req_valid = '0;
    b0.req_data  = '0;
    b1.req_valid = '0;
    b1.req_data  = '0;
    step();
    step();

    chk("rst_busy", 32'(b0.busy), 0);
    chk("rst_ser", 32'(b0.ser_out), 0);
    chk("rst_frm", 32'(b0.ser_frame), 0);
    chk("rst_gid", 32'(b0.grant_id), 0);
    chk("rst_rdy", 32'(b0.req_ready), 0);
    chk("rst_drop", 32'(b0.drop_pulse), 0);
    chk("rst_busy1", 32'(b1.busy), 0);

    // T1: reset in the middle of a frame
    rst = 1'b0;
    b0.req_valid = 4'b0001;
    b0.req_data[7:0] = 8'h5A;
    #1;
    chk("t1_rdy0", 32'(b0.req_ready), 1);
    step();
    b0.req_valid = '0;
    chk("t1_start", 32'(b0.ser_out), 1);
    step();
    step();
    chk("t1_mbusy", 32'(b0.busy), 1);
    chk("t1_mfrm", 32'(b0.ser_frame), 1);
    rst = 1'b1;
    step();
    chk("t1_busy", 32'(b0.busy), 0);
    chk("t1_ser", 32'(b0.ser_out), 0);
    chk("t1_frm", 32'(b0.ser_frame), 0);
    chk("t1_rdy", 32'(b0.req_ready), 0);
    rst = 1'b0;
    b0.req_valid = 4'b0100;
    b0.req_data[23:16] = 8'hC3;
    #1;
    chk("t1_rdy2", 32'(b0.req_ready), 32'h4);
    step();
    b0.req_valid = '0;
    chk("t1_gid", 32'(b0.grant_id), 2);
    chk("t1_st2", 32'(b0.ser_out), 1);
    wait_idle();

    // T2: single A5 frame from requester 1
    exp_a5 = 9'b1_1010_0101;
    b0.req_valid = 4'b0010;
    b0.req_data[15:8] = 8'hA5;
    #1;
    chk("t2_rdy", 32'(b0.req_ready), 32'h2);
    for (int i = 0; i < 9; i++) begin
      step();
      if (i == 0) b0.req_valid = '0;
      chk($sformatf("t2_bit%0d", i), 32'(b0.ser_out),
          32'(exp_a5[8-i]));
      chk($sformatf("t2_frm%0d", i), 32'(b0.ser_frame), 1);
    end
    step();
    chk("t2_gap_ser", 32'(b0.ser_out), 0);
    chk("t2_gap_frm", 32'(b0.ser_frame), 0);
    chk("t2_gap_busy", 32'(b0.busy), 1);
    step();
    chk("t2_idle", 32'(b0.busy), 0);
    chk("t2_gid", 32'(b0.grant_id), 1);

    // T4: move rr_ptr to 3, then wrap and skip
    b0.req_valid = 4'b0100;
    serve(2, "t4p");
    b0.req_valid = 4'b0101;
    serve(0, "t4a");
    serve(2, "t4b");
    b0.req_valid = '0;

    // T3: move rr_ptr to 0, then all four held valid
    b0.req_valid = 4'b1000;
    serve(3, "t3p");
    b0.req_valid = 4'b1111;
    serve(0, "t3g0");
    serve(1, "t3g1");
    serve(2, "t3g2");
    serve(3, "t3g3");
    serve(0, "t3g4");
    b0.req_valid = '0;
    wait_idle();

    // T5: zero-gap back-to-back period on u1
    n_hs = 0;
    pend = 1'b0;
    b1.req_valid = 4'b0001;
    b1.req_data[7:0] = seq;
    for (int c = 0; c < 60 && n_hs < 3; c++) begin
      if (pend) begin
        seq = seq + 8'd1;
        b1.req_data[7:0] = seq;
        pend = 1'b0;
      end
      #1;
      if (b1.req_ready != '0) begin
        hs_t[n_hs] = c;
        n_hs++;
        pend = 1'b1;
      end
      step();
    end
    b1.req_valid = '0;
    chk("t5_count", 32'(n_hs), 3);
    chk("t5_per0", 32'(hs_t[1] - hs_t[0]), 10);
    chk("t5_per1", 32'(hs_t[2] - hs_t[1]), 10);

    // T6: duplicate words from requester 0
`ifdef DUP_SUPPRESS_EN
    tx(8'h3C, 1'b1, "t6a");
    tx(8'h3C, 1'b0, "t6b");
    tx(8'h3D, 1'b1, "t6c");
`else
    tx(8'h3C, 1'b1, "t6a");
    tx(8'h3C, 1'b1, "t6b");
    tx(8'h3D, 1'b1, "t6c");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
